rom_port_arbiter: RTL and testbench

//  Owns the 14-bit, 32-bit-wide instruction RAMROM port and shares it between the

---
 rtl/rom_arb_pkg.sv | 15 +
 rtl/rom_byte_packer.sv | 62 ++++++
 rtl/rom_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and widths for the instruction RAMROM port arbiter.
package rom_arb_pkg;

    localparam int ROM_AW = 14;
    localparam int ROM_DW = 32;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DRAIN  = 3'd1,
        LOAD   = 3'd2,
        FLUSH  = 3'd3,
        RESUME = 3'd4
    } state_t;

endpackage

// File: rtl/rom_byte_packer.sv
// Packs loader bytes little-endian into 32-bit words. A full word raises
// word_valid_o for one cycle after its 4th byte; a flush with 1-3 bytes
// pending raises it combinationally with the upper bytes already zero.
module rom_byte_packer
    import rom_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              byte_fire_i,
    input  logic [7:0]        byte_i,
    input  logic              flush_i,
    output logic              word_valid_o,
    output logic [ROM_DW-1:0] word_o,
    output logic              busy_o
);

    logic [1:0]        cnt_q, cnt_d;
    logic [ROM_DW-1:0] data_q, data_d;
    logic              wv_q, wv_d;

    // Byte slotting: the first byte of a word zeroes the rest so a flush
    // never needs a separate padding step.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        wv_d   = 1'b0;
        if (clear_i) begin
            cnt_d  = '0;
            data_d = '0;
        end else if (flush_i) begin
            cnt_d = '0;
        end else if (byte_fire_i) begin
            if (cnt_q == 2'd0) begin
                data_d = {24'h0, byte_i};
            end else begin
                data_d[{cnt_q, 3'b000} +: 8] = byte_i;
            end
            wv_d  = (cnt_q == 2'd3);
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Packer state; reset discards any partially assembled word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            data_q <= '0;
            wv_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
            wv_q   <= wv_d;
        end
    end

    assign word_valid_o = wv_q | (flush_i & (cnt_q != 2'd0));
    assign word_o       = data_q;
    // The word is held in data_q during its write cycle, so no new byte may land.
    assign busy_o       = wv_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the instruction RAMROM port between the fetch unit and the UART
// program loader: stall, drain, grant, pack/write, flush, resume.
// Optional build macro LOADER_CHECKSUM_EN adds ld_checksum (sum of words written).
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned       DRAIN_CYCLES       = 2,
    parameter logic [ROM_AW-1:0] LOAD_BASE          = 14'h0,
    parameter bit                RESTART_AFTER_LOAD = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ROM_AW-1:0] fetch_adr,
    output logic [ROM_DW-1:0] fetch_inst,
    output logic              cpu_stall,
    output logic              cpu_restart,
    input  logic              ld_req,
    output logic              ld_gnt,
    input  logic [7:0]        ld_byte,
    input  logic              ld_byte_valid,
    output logic              ld_byte_ready,
    input  logic              ld_done,
    output logic [ROM_AW-1:0] ld_word_count,
    output logic              ld_wrapped,
    output logic [ROM_AW-1:0] rom_adr,
    output logic [ROM_DW-1:0] rom_wdata,
    output logic              rom_we,
    input  logic [ROM_DW-1:0] rom_rdata
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [ROM_DW-1:0] ld_checksum
`endif
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    state_t            state_q, state_d;
    logic [DCW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [ROM_AW-1:0] wr_adr_q, wr_adr_d;
    logic [ROM_AW-1:0] word_cnt_q, word_cnt_d;
    logic              wrapped_q, wrapped_d;
    logic [ROM_DW-1:0] inst_q, inst_d;
    logic              restart_q, restart_d;
    logic              rdata_ok_q;

    logic              drain_done, enter_drain;
    logic              pk_fire, pk_flush, pk_wv, pk_busy;
    logic [ROM_DW-1:0] pk_word;

    assign drain_done  = (state_q == DRAIN) && (drain_cnt_q == DRAIN_LAST);
    assign enter_drain = (state_q == FETCH) && ld_req;
    assign pk_flush    = (state_q == FLUSH);
    assign pk_fire     = (state_q == LOAD) && ld_byte_valid && !pk_busy;

    rom_byte_packer u_packer (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (drain_done),
        .byte_fire_i (pk_fire),
        .byte_i      (ld_byte),
        .flush_i     (pk_flush),
        .word_valid_o(pk_wv),
        .word_o      (pk_word),
        .busy_o      (pk_busy)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state: a loader session always runs FLUSH and RESUME once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (ld_req) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = LOAD;
            LOAD:    if (ld_done || !ld_req) state_d = FLUSH;
            FLUSH:   state_d = RESUME;
            RESUME:  state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Outputs: fetch path owns the port except in LOAD/FLUSH.
    always_comb begin
        rom_adr       = fetch_adr;
        rom_we        = 1'b0;
        rom_wdata     = '0;
        fetch_inst    = inst_q;
        cpu_stall     = 1'b1;
        ld_gnt        = 1'b0;
        ld_byte_ready = 1'b0;
        case (state_q)
            FETCH: begin
                cpu_stall  = 1'b0;
                // rom_rdata is only meaningful once an edge outside reset has
                // registered a read address.
                fetch_inst = rdata_ok_q ? rom_rdata : inst_q;
            end
            LOAD: begin
                ld_gnt        = 1'b1;
                ld_byte_ready = !pk_busy;
                rom_adr       = wr_adr_q;
                rom_we        = pk_wv;
                rom_wdata     = pk_wv ? pk_word : '0;
            end
            FLUSH: begin
                ld_gnt    = 1'b1;
                rom_adr   = wr_adr_q;
                rom_we    = pk_wv;
                rom_wdata = pk_wv ? pk_word : '0;
            end
            default: ;
        endcase
    end

    // Datapath next-state: drain timer, write pointer, session counters.
    always_comb begin
        drain_cnt_d = (state_q == DRAIN) ? drain_cnt_q + 1'b1 : '0;
        wr_adr_d    = wr_adr_q;
        word_cnt_d  = word_cnt_q;
        wrapped_d   = wrapped_q;
        if (drain_done) begin
            wr_adr_d   = LOAD_BASE;
            word_cnt_d = '0;
            wrapped_d  = 1'b0;
        end else if (rom_we) begin
            wr_adr_d   = wr_adr_q + 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
            if (wr_adr_q == '1) wrapped_d = 1'b1;
        end
        inst_d    = (state_q == FETCH) ? fetch_inst : inst_q;
        restart_d = RESTART_AFTER_LOAD && (state_q == RESUME);
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drain_cnt_q <= '0;
            wr_adr_q    <= LOAD_BASE;
            word_cnt_q  <= '0;
            wrapped_q   <= 1'b0;
            inst_q      <= '0;
            restart_q   <= 1'b0;
            rdata_ok_q  <= 1'b0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
            wr_adr_q    <= wr_adr_d;
            word_cnt_q  <= word_cnt_d;
            wrapped_q   <= wrapped_d;
            inst_q      <= inst_d;
            restart_q   <= restart_d;
            rdata_ok_q  <= 1'b1;
        end
    end

    assign cpu_restart   = restart_q;
    assign ld_word_count = word_cnt_q;
    assign ld_wrapped    = wrapped_q;

`ifdef LOADER_CHECKSUM_EN
    logic [ROM_DW-1:0] csum_q, csum_d;

    // Session checksum, restarted whenever a new session begins draining.
    always_comb begin
        csum_d = csum_q;
        if (enter_drain)  csum_d = '0;
        else if (rom_we)  csum_d = csum_q + rom_wdata;
    end

    // Checksum register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign ld_checksum = csum_q;
`else
    logic unused_enter_drain;
    assign unused_enter_drain = enter_drain;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: two instances (LOAD_BASE 0 and 3FFF) share the
// stimulus; each has its own RAMROM model with 1-cycle read latency.
module tb_rom_port_arbiter;

    localparam int D = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [13:0] fetch_adr;
    logic        ld_req, ld_done, ld_byte_valid;
    logic [7:0]  ld_byte;

    logic [31:0] fetch_inst [2];
    logic        cpu_stall [2], cpu_restart [2], ld_gnt [2], ld_byte_ready [2];
    logic        ld_wrapped [2], rom_we [2];
    logic [13:0] ld_word_count [2], rom_adr [2];
    logic [31:0] rom_wdata [2], rom_rdata [2], ld_checksum [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] img [$];
    bit [31:0]  mdl [2][16384];
    bit         mdlw [2][16384];

    always #5 clock = ~clock;

    // Unwritten RAMROM words read back as an address-derived pattern.
    function automatic logic [31:0] pat(input logic [13:0] a);
        return 32'h2408_0000 + {18'h0, a} - 32'd15;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bit [31:0]   mem [16384];
        bit          mwr [16384];
        logic [45:0] wlog [$];
        int          rcnt = 0;

        rom_port_arbiter #(
            .DRAIN_CYCLES(D),
            .LOAD_BASE(g == 0 ? 14'h0000 : 14'h3FFF),
            .RESTART_AFTER_LOAD(1'b1)
        ) u_dut (
            .clock(clock), .reset(reset), .fetch_adr(fetch_adr),
            .fetch_inst(fetch_inst[g]), .cpu_stall(cpu_stall[g]),
            .cpu_restart(cpu_restart[g]), .ld_req(ld_req), .ld_gnt(ld_gnt[g]),
            .ld_byte(ld_byte), .ld_byte_valid(ld_byte_valid),
            .ld_byte_ready(ld_byte_ready[g]), .ld_done(ld_done),
            .ld_word_count(ld_word_count[g]), .ld_wrapped(ld_wrapped[g]),
            .rom_adr(rom_adr[g]), .rom_wdata(rom_wdata[g]), .rom_we(rom_we[g]),
            .rom_rdata(rom_rdata[g])
`ifdef LOADER_CHECKSUM_EN
            , .ld_checksum(ld_checksum[g])
`endif
        );
`ifndef LOADER_CHECKSUM_EN
        assign ld_checksum[g] = 32'h0;
`endif

        always @(posedge clock) begin
            if (rom_we[g]) begin
                mem[rom_adr[g]] <= rom_wdata[g];
                mwr[rom_adr[g]] <= 1'b1;
                wlog.push_back({rom_adr[g], rom_wdata[g]});
            end
            rom_rdata[g] <= mwr[rom_adr[g]] ? mem[rom_adr[g]] : pat(rom_adr[g]);
            if (cpu_restart[g]) rcnt <= rcnt + 1;
        end
    end

    function automatic int log_size(input int g);
        return (g == 0) ? g_dut[0].wlog.size() : g_dut[1].wlog.size();
    endfunction
    function automatic logic [45:0] log_at(input int g, input int i);
        return (g == 0) ? g_dut[0].wlog[i] : g_dut[1].wlog[i];
    endfunction
    function automatic int rst_cnt(input int g);
        return (g == 0) ? g_dut[0].rcnt : g_dut[1].rcnt;
    endfunction

    // Expected word i of the current image: little-endian, zero-padded.
    function automatic logic [31:0] mword(input int i);
        logic [31:0] w = 32'h0;
        for (int j = 0; j < 4; j++)
            if (4 * i + j < img.size()) w = w | ({24'h0, img[4 * i + j]} << (8 * j));
        return w;
    endfunction

    function automatic logic [31:0] exp_mem(input int g, input logic [13:0] a);
        return mdlw[g][a] ? mdl[g][a] : pat(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise ld_req at a negedge and count edges until the grant shows.
    task automatic start_load();
        int lat = 0;
        ld_req = 1'b1;
        do begin
            @(negedge clock);
            lat++;
        end while (!ld_gnt[0] && lat < 20);
        chk("gnt_latency", 32'(lat), 32'(D + 1));
        chk("gnt_both", {31'h0, ld_gnt[1]}, 32'h1);
    endtask

    // Push img[0..n-1] with random valid gaps. mode 1 ends the image with
    // ld_done (and ld_req low) in the same cycle as the last byte.
    task automatic send_bytes(input int n, input int mode);
        int  idx = 0;
        int  guard = 0;
        bit  take, fin;
        while (idx < n && guard < 500) begin
            guard++;
            fin = 1'b0;
            if ($urandom_range(3, 0) == 0) begin
                ld_byte_valid = 1'b0;
                ld_byte       = 8'($urandom);
            end else begin
                ld_byte_valid = 1'b1;
                ld_byte       = img[idx];
                if (mode == 1 && idx == n - 1 && ld_byte_ready[0]) begin
                    ld_done = 1'b1;
                    ld_req  = 1'b0;
                    fin     = 1'b1;
                end
            end
            take = ld_byte_valid && ld_byte_ready[0];
            @(negedge clock);
            ld_done = 1'b0;
            if (take) idx++;
            if (fin) ld_byte_valid = 1'b0;
        end
        ld_byte_valid = 1'b0;
        chk("bytes_sent", 32'(idx), 32'(n));
    endtask

    task automatic session(input string name, input int mode);
        int          n = img.size();
        int          nw = (n + 3) / 4;
        int          s [2];
        int          r [2];
        int          guard = 0;
        int          got, base;
        logic [45:0] e;
        logic [13:0] ea;
        logic [31:0] sum;
        for (int g = 0; g < 2; g++) begin
            s[g] = log_size(g);
            r[g] = rst_cnt(g);
        end
        start_load();
        send_bytes(n, mode);
        if (mode == 0 || (mode == 1 && n == 0)) begin
            ld_done = 1'b1;
            ld_req  = 1'b0;
            @(negedge clock);
            ld_done = 1'b0;
        end else if (mode == 2) begin
            ld_req = 1'b0;
        end
        while (cpu_stall[0] && guard < 60) begin
            @(negedge clock);
            guard++;
        end
        chk({name, "_resume_bound"}, {31'h0, guard < 60}, 32'h1);
        chk({name, "_restart_now"}, {31'h0, cpu_restart[0]}, 32'h1);
        @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            base = (g == 0) ? 0 : 16383;
            sum  = 32'h0;
            got  = log_size(g) - s[g];
            chk({name, "_nwrites"}, 32'(got), 32'(nw));
            for (int i = 0; i < nw && i < got; i++) begin
                e  = log_at(g, s[g] + i);
                ea = 14'(base + i);
                chk({name, "_wadr"}, {18'h0, e[45:32]}, {18'h0, ea});
                chk({name, "_wdata"}, e[31:0], mword(i));
                mdl[g][ea]  = mword(i);
                mdlw[g][ea] = 1'b1;
                sum = sum + mword(i);
            end
            chk({name, "_wcount"}, {18'h0, ld_word_count[g]}, 32'(nw));
            chk({name, "_wrapped"}, {31'h0, ld_wrapped[g]},
                {31'h0, (nw > 0) && (base + nw >= 16384)});
            chk({name, "_restarts"}, 32'(rst_cnt(g) - r[g]), 32'h1);
`ifdef LOADER_CHECKSUM_EN
            chk({name, "_csum"}, ld_checksum[g], sum);
`endif
        end
    endtask

    task automatic fetch_check(input string name, input logic [13:0] a);
        fetch_adr = a;
        @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            chk({name, "_inst"}, fetch_inst[g], exp_mem(g, a));
            chk({name, "_stall"}, {31'h0, cpu_stall[g]}, 32'h0);
        end
    endtask

    initial begin
        int s0;
        reset = 1'b1; ld_req = 1'b0; ld_done = 1'b0; ld_byte_valid = 1'b0;
        ld_byte = 8'h0; fetch_adr = 14'h0010;
        repeat (2) @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            chk("rst_stall", {31'h0, cpu_stall[g]}, 32'h0);
            chk("rst_restart", {31'h0, cpu_restart[g]}, 32'h0);
            chk("rst_gnt", {31'h0, ld_gnt[g]}, 32'h0);
            chk("rst_ready", {31'h0, ld_byte_ready[g]}, 32'h0);
            chk("rst_we", {31'h0, rom_we[g]}, 32'h0);
            chk("rst_wdata", rom_wdata[g], 32'h0);
            chk("rst_count", {18'h0, ld_word_count[g]}, 32'h0);
            chk("rst_wrapped", {31'h0, ld_wrapped[g]}, 32'h0);
            chk("rst_inst", fetch_inst[g], 32'h0);
        end
        reset = 1'b0;
        @(negedge clock);
        chk("idle_inst", fetch_inst[0], 32'h2408_0001);
        chk("idle_stall", {31'h0, cpu_stall[0]}, 32'h0);
        for (int i = 0; i < 4; i++) fetch_check("idle_rand", 14'($urandom));

        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        session("img8", 0);
`ifdef LOADER_CHECKSUM_EN
        chk("img8_csum_const", ld_checksum[0], 32'h0C0A_0806);
`endif
        chk("img8_word1", g_dut[0].mem[1], 32'h0807_0605);
        fetch_check("post8_a0", 14'h0000);
        fetch_check("post8_a1", 14'h0001);

        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        session("img5", 1);
        chk("img5_word1", g_dut[0].mem[1], 32'h0000_00EE);

        img = {};
        for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
        session("reqdrop", 2);

        // Reset after 2 bytes of a word: nothing may be written.
        s0 = log_size(0);
        img = '{8'h5A, 8'hA5};
        start_load();
        send_bytes(2, 3);
        reset = 1'b1;
        #1;
        chk("midrst_stall", {31'h0, cpu_stall[0]}, 32'h0);
        chk("midrst_gnt", {31'h0, ld_gnt[0]}, 32'h0);
        chk("midrst_count", {18'h0, ld_word_count[0]}, 32'h0);
        ld_req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("midrst_nowrite", 32'(log_size(0) - s0), 32'h0);
        chk("midrst_idle", {31'h0, cpu_stall[0]}, 32'h0);

        for (int k = 0; k < 6; k++) begin
            img = {};
            for (int i = 0; i < int'($urandom_range(13, 0)); i++) img.push_back(8'($urandom));
            session("rand", int'($urandom_range(2, 0)));
            fetch_check("rand_fetch", 14'($urandom_range(3, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
